am2923r: RTL and testbench

AM2923R -- requirements
Module: am2923r

---
 rtl/am2923r_if.sv | 27 ++
 rtl/am2923r.sv | 101 ++++++++++
 tb/tb_am2923r.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/am2923r_if.sv
// AM2923R control/status bundle: mode, address, data, handshake and flags.
// Ports: d,a,b,c,e_,m,start,ack,oe_ (to block); sel,busy,rdy,ovr (from block).
interface am2923r_if;
   logic       d;
   logic       a;
   logic       b;
   logic       c;
   logic       e_;
   logic       m;
   logic       start;
   logic       ack;
   logic       oe_;
   logic [2:0] sel;
   logic       busy;
   logic       rdy;
   logic       ovr;

   modport master (
      output d, a, b, c, e_, m, start, ack, oe_,
      input  sel, busy, rdy, ovr
   );

   modport slave (
      input  d, a, b, c, e_, m, start, ack, oe_,
      output sel, busy, rdy, ovr
   );
endinterface

// File: rtl/am2923r.sv
// AM2923R: 8-bit addressable latch (m=0) / LSB-first frame deserializer (m=1).
// Ports: clk, clr_ (async low reset), bus (am2923r_if.slave), q (tri-state out).
module am2923r (
   input  logic        clk,
   input  logic        clr_,
   am2923r_if.slave    bus,
   output wire  [7:0]  q
);
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t     r_st,   w_st_n;
   logic [7:0] r_q,    w_q_n;
   logic [7:0] r_sr,   w_sr_n;
   logic [2:0] r_cnt,  w_cnt_n;
   logic       r_rdy,  w_rdy_n;
   logic       r_ovr,  w_ovr_n;
   logic       w_cap;
   logic [2:0] w_addr;

   assign w_addr = {bus.c, bus.b, bus.a};

   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         r_st  <= IDLE;
         r_q   <= 8'h00;
         r_sr  <= 8'h00;
         r_cnt <= 3'd0;
         r_rdy <= 1'b0;
         r_ovr <= 1'b0;
      end else begin
         r_st  <= w_st_n;
         r_q   <= w_q_n;
         r_sr  <= w_sr_n;
         r_cnt <= w_cnt_n;
         r_rdy <= w_rdy_n;
         r_ovr <= w_ovr_n;
      end
   end

   always_comb begin
      w_st_n  = r_st;
      w_q_n   = r_q;
      w_sr_n  = r_sr;
      w_cnt_n = r_cnt;
      w_cap   = 1'b0;
      if (!bus.m) begin
         // Leaving mode 1 aborts any partial frame.
         w_st_n  = IDLE;
         w_cnt_n = 3'd0;
         if (!bus.e_)
            w_q_n[w_addr] = bus.d;
      end else begin
         unique case (r_st)
            IDLE: begin
               w_cnt_n = 3'd0;
               if (bus.start)
                  w_st_n = SHIFT;
            end
            SHIFT: begin
               if (r_cnt != 3'd7) begin
                  w_sr_n[r_cnt] = bus.d;
                  w_cnt_n       = r_cnt + 3'd1;
               end else begin
                  w_cap   = 1'b1;
                  w_q_n   = {bus.d, r_sr[6:0]};
                  w_cnt_n = 3'd0;
                  // start on the last bit chains the next frame.
                  w_st_n  = bus.start ? SHIFT : IDLE;
               end
            end
            default: begin
               w_st_n  = IDLE;
               w_cnt_n = 3'd0;
            end
         endcase
      end
   end

   // ack on a capture edge only retires the old frame: ovr is left alone.
   always_comb begin
      w_rdy_n = r_rdy;
      w_ovr_n = r_ovr;
      if (w_cap) begin
         w_rdy_n = 1'b1;
         if (r_rdy && !bus.ack)
            w_ovr_n = 1'b1;
      end else if (bus.ack) begin
         w_rdy_n = 1'b0;
         w_ovr_n = 1'b0;
      end
   end

   assign bus.sel  = r_cnt;
   assign bus.busy = (r_st == SHIFT);
   assign bus.rdy  = r_rdy;
   assign bus.ovr  = r_ovr;
   assign q        = bus.oe_ ? 8'hzz : r_q;
endmodule

// File: tb/tb_am2923r.sv
// Directed bench for am2923r: latch writes, framing, overrun, abort, reset.
// Expected values are hand-computed constants.
module tb_am2923r;
   logic       clk;
   logic       clr_;
   wire  [7:0] q;
   int         n_chk;
   int         n_pass;

   am2923r_if bus ();

   am2923r u_dut (
      .clk  (clk),
      .clr_ (clr_),
      .bus  (bus.slave),
      .q    (q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
   endtask

   // Shift 8 bits LSB first; start/ack applied on the last bit edge.
   task automatic send(input logic [7:0] v, input logic st_last,
                       input logic ack_last);
      for (int i = 0; i < 8; i++) begin
         bus.d = v[i];
         if (i == 7) begin
            bus.start = st_last;
            bus.ack   = ack_last;
         end
         chk("sel_step", {29'd0, bus.sel}, i);
         step();
      end
      bus.start = 1'b0;
      bus.ack   = 1'b0;
   endtask

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      clr_      = 1'b0;
      bus.d     = 1'b0;
      bus.a     = 1'b0;
      bus.b     = 1'b0;
      bus.c     = 1'b0;
      bus.e_    = 1'b1;
      bus.m     = 1'b0;
      bus.start = 1'b0;
      bus.ack   = 1'b0;
      bus.oe_   = 1'b0;
      #2;
      chk("rst_q", {24'd0, q}, 32'h00);
      chk("rst_sel", {29'd0, bus.sel}, 0);
      chk("rst_busy", {31'd0, bus.busy}, 0);
      chk("rst_rdy", {31'd0, bus.rdy}, 0);
      chk("rst_ovr", {31'd0, bus.ovr}, 0);
      #5;
      clr_ = 1'b1;
      step();

      // Addressable latch writes
      bus.e_ = 1'b0;
      bus.d  = 1'b1;
      {bus.c, bus.b, bus.a} = 3'd5;
      step();
      chk("m0_w5", {24'd0, q}, 32'h20);
      {bus.c, bus.b, bus.a} = 3'd2;
      step();
      chk("m0_w2", {24'd0, q}, 32'h24);
      bus.d = 1'b0;
      {bus.c, bus.b, bus.a} = 3'd5;
      step();
      chk("m0_c5", {24'd0, q}, 32'h04);
      bus.e_ = 1'b1;
      bus.d  = 1'b1;
      step();
      chk("m0_hold", {24'd0, q}, 32'h04);
      bus.oe_ = 1'b1;
      #1;
      n_chk++;
      assert (q === 8'hzz) n_pass++;
      else $error("FAIL oe_hiz obs=%h exp=zz", q);
      bus.oe_ = 1'b0;
      #1;
      chk("oe_back", {24'd0, q}, 32'h04);

      // Single frame A5
      bus.m     = 1'b1;
      bus.start = 1'b1;
      step();
      chk("f1_busy", {31'd0, bus.busy}, 1);
      bus.start = 1'b0;
      send(8'hA5, 1'b0, 1'b0);
      chk("f1_q", {24'd0, q}, 32'hA5);
      chk("f1_rdy", {31'd0, bus.rdy}, 1);
      chk("f1_idle", {31'd0, bus.busy}, 0);
      chk("f1_ovr", {31'd0, bus.ovr}, 0);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      chk("f1_ack", {31'd0, bus.rdy}, 0);

      // Back-to-back 3C, C3 without ack -> overrun
      bus.start = 1'b1;
      step();
      send(8'h3C, 1'b1, 1'b0);
      chk("bb_q1", {24'd0, q}, 32'h3C);
      chk("bb_rdy1", {31'd0, bus.rdy}, 1);
      chk("bb_ovr1", {31'd0, bus.ovr}, 0);
      chk("bb_busy1", {31'd0, bus.busy}, 1);
      send(8'hC3, 1'b1, 1'b0);
      chk("bb_q2", {24'd0, q}, 32'hC3);
      chk("bb_rdy2", {31'd0, bus.rdy}, 1);
      chk("bb_ovr2", {31'd0, bus.ovr}, 1);
      chk("bb_busy2", {31'd0, bus.busy}, 1);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      chk("bb_ack_rdy", {31'd0, bus.rdy}, 0);
      chk("bb_ack_ovr", {31'd0, bus.ovr}, 0);
      bus.m = 1'b0;
      step();
      chk("bb_abort", {31'd0, bus.busy}, 0);
      chk("bb_abort_q", {24'd0, q}, 32'hC3);

      // Capture with ack on the same edge
      bus.m     = 1'b1;
      bus.start = 1'b1;
      step();
      send(8'h55, 1'b1, 1'b0);
      chk("ca_q1", {24'd0, q}, 32'h55);
      chk("ca_rdy1", {31'd0, bus.rdy}, 1);
      send(8'h0F, 1'b0, 1'b1);
      chk("ca_q2", {24'd0, q}, 32'h0F);
      chk("ca_rdy2", {31'd0, bus.rdy}, 1);
      chk("ca_ovr2", {31'd0, bus.ovr}, 0);

      // Abort of frame FF at cnt=4
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.d     = 1'b1;
      repeat (4) step();
      chk("ab_sel4", {29'd0, bus.sel}, 4);
      bus.m = 1'b0;
      step();
      chk("ab_busy", {31'd0, bus.busy}, 0);
      chk("ab_sel", {29'd0, bus.sel}, 0);
      chk("ab_q", {24'd0, q}, 32'h0F);
      chk("ab_rdy", {31'd0, bus.rdy}, 1);
      bus.e_ = 1'b0;
      bus.d  = 1'b1;
      {bus.c, bus.b, bus.a} = 3'd7;
      step();
      bus.e_ = 1'b1;
      chk("m0_q8f", {24'd0, q}, 32'h8F);
      chk("m0_rdy", {31'd0, bus.rdy}, 1);

      // Reset mid-frame
      bus.m     = 1'b1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (3) step();
      chk("mr_sel3", {29'd0, bus.sel}, 3);
      #2;
      clr_ = 1'b0;
      #1;
      chk("mr_sel", {29'd0, bus.sel}, 0);
      chk("mr_busy", {31'd0, bus.busy}, 0);
      chk("mr_rdy", {31'd0, bus.rdy}, 0);
      chk("mr_ovr", {31'd0, bus.ovr}, 0);
      chk("mr_q", {24'd0, q}, 32'h00);
      #1;
      clr_ = 1'b1;
      bus.m  = 1'b0;
      bus.e_ = 1'b0;
      bus.d  = 1'b1;
      {bus.c, bus.b, bus.a} = 3'd3;
      step();
      bus.e_ = 1'b1;
      chk("pr_q", {24'd0, q}, 32'h08);
      chk("pr_busy", {31'd0, bus.busy}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
